rv32i_memoryaccess: RTL and testbench
=====================================

Name: rv32i_memoryaccess

Overview:
- Memory-access stage directly upstream of the writeback stage.
- Takes the effective address (rs1+imm) and rs2 from the execute stage for LOAD/STORE instructions.
- Runs one byte-enabled, word-aligned transaction on a simple strobe/ack data bus.
- Delivers a sign- or zero-extended `data_load` word and a one-cycle completion pulse; the control FSM uses that pulse to advance into WRITEBACK.

Parameters:
- TIMEOUT, 255: max cycles `o_stb` may stay high without `i_ack` before the access aborts with a bus error (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request pulse; honoured only in IDLE
- i_load  in  1  instruction is LOAD
- i_store  in  1  instruction is STORE
- i_funct3  in  3  [1:0] size (00 byte, 01 half, 1x word); [2] unsigned load
- i_addr  in  32  effective byte address
- i_rs2  in  32  store data
- o_busy  out  1  high whenever the FSM is not IDLE
- o_done  out  1  one-cycle completion pulse
- o_data_load  out  32  extended load result, consumed by writeback
- o_misaligned  out  1  valid with o_done: misaligned access, no bus cycle issued
- o_bus_err  out  1  valid with o_done: timeout abort
- o_stb  out  1  bus request
- o_we  out  1  bus write enable
- o_addr  out  32  bus address, bits [1:0] always 0
- o_wdata  out  32  bus write data
- o_sel  out  4  byte-lane enables
- i_ack  in  1  bus acknowledge
- i_rdata  in  32  bus read data, valid when i_ack=1

Behaviour:
- Reset: on the next edge with rst=1, state=IDLE and every output is 0; an in-flight o_stb drops at that edge and no o_done is produced.
- FSM states: IDLE, REQ, DONE.
- Accepting a request: i_start=1 in IDLE is sampled; i_start in any other state is ignored.
- Size: funct3[1:0]=00 byte, 01 half, 10/11 word. funct3[2] is ignored for stores.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. A misaligned request or a request with neither i_load nor i_store goes IDLE->DONE with no bus cycle; o_misaligned=1 only in the misaligned case.
- Store priority: if i_load and i_store are both 1, the request is treated as a store.
- Bus start: an aligned request goes IDLE->REQ. From the next cycle o_stb=1, o_addr={addr[31:2],2'b00} and o_we=store.
- o_sel: byte = 0001<<addr[1:0]; half = 0011 if addr[1]=0, else 1100; word = 1111.
- o_wdata: byte = rs2[7:0] replicated x4; half = rs2[15:0] replicated x2; word = rs2.
- REQ hold: o_stb, o_we, o_addr, o_wdata and o_sel are held constant until i_ack=1 is sampled.
- Ack edge: o_stb falls, i_rdata is captured, and the FSM enters DONE.
- Load result: o_data_load = selected lane, sign-extended (funct3[2]=0) or zero-extended.
- Store / no-op / fault result: o_data_load=0.
- Timeout: a cycle counter runs in REQ. When it reaches TIMEOUT without ack, o_stb falls, the FSM enters DONE with o_bus_err=1, and o_data_load=0.
- Late ack: i_ack outside REQ is ignored.
- DONE: o_done=1 for exactly one cycle, then the FSM returns to IDLE.
- Flag hold: o_data_load, o_misaligned and o_bus_err hold their values until the next request completes.
- Latency: with start at cycle T and ack first sampled at T+1+k, o_stb is high from T+1 to T+1+k and o_done pulses at T+2+k.
- No-bus latency: no-op and misaligned requests pulse o_done at T+1.
- Busy window: o_busy is high from T+1 through the o_done cycle.
- Back-to-back: a new i_start is accepted in the cycle after o_done.

Decomposition:
- Shared header (rv32i_header.vh) holds:
  - funct3 size codes (BYTE=2'b00, HALF=2'b01, WORD=2'b10);
  - FSM state encodings;
  - an opcode-independent LSU fault-code localparam.
- One sub-module, rv32i_load_extend: combinational lane select plus sign/zero extension.
  - Inputs: i_rdata, addr[1:0], funct3.
  - Output: 32-bit extended result.
  - The main module keeps the FSM, timeout counter, lane/sel generation and the output registers.

Test Plan:
- LB at addr 0x103 with i_rdata=0x80_00_00_00 and ack after 2 wait cycles -> o_sel=1000, o_addr=0x100, o_data_load=0xFFFF_FF80, o_done at T+4.
- LHU at 0x202 with rdata=0xBEEF_1234 and immediate ack -> o_sel=1100, o_data_load=0x0000_BEEF, o_done at T+2, o_busy high T+1..T+2.
- SB at 0x011 with rs2=0x1234_56AB -> o_we=1, o_sel=0010, o_wdata=0xABAB_ABAB, o_addr=0x010, o_data_load=0.
- LW at 0x006 -> o_stb never asserted, o_done at T+1 with o_misaligned=1; SH at 0x005 behaves the same.
- TIMEOUT=4, SW with i_ack held 0 -> o_stb high for 4 cycles, then o_done with o_bus_err=1; a later spurious i_ack has no effect.
- rst=1 while o_stb is high mid-LW -> next edge all outputs 0 and IDLE, no o_done; an i_start while busy is ignored, with no second transaction.

Source files
------------

// File: rtl/rv32i_memoryaccess_pkg.sv
// Shared definitions for the RV32I memory-access stage: size codes, FSM states,
// LSU fault codes and the store lane helpers.
package rv32i_memoryaccess_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Outcome of the last completed access, independent of the opcode.
  localparam logic [1:0] LSU_FAULT_NONE     = 2'd0;
  localparam logic [1:0] LSU_FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] LSU_FAULT_BUSERR   = 2'd2;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_sel = 4'b0001 << lane;
      SZ_HALF: lane_sel = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      SZ_BYTE: lane_wdata = {4{rs2[7:0]}};
      SZ_HALF: lane_wdata = {2{rs2[15:0]}};
      default: lane_wdata = rs2;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_extend.sv
// Picks the addressed byte/half/word lane out of a bus read word and
// sign- or zero-extends it to 32 bits.
module rv32i_load_extend
  import rv32i_memoryaccess_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_sext = ~i_funct3[2];
    case (i_funct3[1:0])
      SZ_BYTE: o_data = {{24{w_sext & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{w_sext & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_memoryaccess.sv
// RV32I memory-access stage: one byte-enabled, word-aligned strobe/ack bus
// transaction per request, with timeout abort and a one-cycle done pulse.
module rv32i_memoryaccess
  import rv32i_memoryaccess_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_data_load,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_stb,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_sel,
  input  logic        i_ack,
  input  logic [31:0] i_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_stb;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_sel;
  logic [1:0]        r_lane;
  logic [2:0]        r_funct3;
  logic              r_load_op;
  logic [31:0]       r_data_load;
  logic [1:0]        r_fault;

  logic              w_access;
  logic              w_misal;
  logic              w_bus_go;
  logic              w_timeout;
  logic [31:0]       w_ext;

  always_comb begin
    w_access  = i_load | i_store;
    w_misal   = ((i_funct3[1:0] == SZ_HALF) & i_addr[0]) |
                (i_funct3[1] & (i_addr[1:0] != 2'b00));
    w_bus_go  = w_access & ~w_misal;
    w_timeout = (r_cnt == CNT_LAST);
  end

  rv32i_load_extend u_load_extend (
    .i_rdata  (i_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = w_bus_go ? ST_REQ : ST_DONE;
      ST_REQ:  if (i_ack || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_data_load <= '0;
      r_fault     <= LSU_FAULT_NONE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_cnt     <= '0;
          r_lane    <= i_addr[1:0];
          r_funct3  <= i_funct3;
          r_load_op <= i_load & ~i_store;
          if (w_bus_go) begin
            r_stb   <= 1'b1;
            r_we    <= i_store;
            r_addr  <= {i_addr[31:2], 2'b00};
            r_wdata <= lane_wdata(i_funct3[1:0], i_rs2);
            r_sel   <= lane_sel(i_funct3[1:0], i_addr[1:0]);
          end else begin
            r_data_load <= '0;
            r_fault     <= (w_access & w_misal) ? LSU_FAULT_MISALIGN : LSU_FAULT_NONE;
          end
        end
        // Ack wins over a timeout landing on the same cycle.
        ST_REQ: if (i_ack) begin
          r_stb       <= 1'b0;
          r_data_load <= r_load_op ? w_ext : 32'h0;
          r_fault     <= LSU_FAULT_NONE;
        end else if (w_timeout) begin
          r_stb       <= 1'b0;
          r_data_load <= '0;
          r_fault     <= LSU_FAULT_BUSERR;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_DONE);
  assign o_data_load  = r_data_load;
  assign o_misaligned = (r_fault == LSU_FAULT_MISALIGN);
  assign o_bus_err    = (r_fault == LSU_FAULT_BUSERR);
  assign o_stb        = r_stb;
  assign o_we         = r_we;
  assign o_addr       = r_addr;
  assign o_wdata      = r_wdata;
  assign o_sel        = r_sel;

endmodule

// File: tb/tb_rv32i_memoryaccess.sv
// Bench for rv32i_memoryaccess: directed vector table, randomized transactions
// against a byte-level reference model, and timeout/reset/busy sequences.
module tb_rv32i_memoryaccess;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_load, i_store, i_ack;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_rs2, i_rdata;
  logic        o_busy, o_done, o_misaligned, o_bus_err, o_stb, o_we;
  logic [31:0] o_data_load, o_addr, o_wdata;
  logic [3:0]  o_sel;

  int n_checks = 0;
  int n_errors = 0;

  rv32i_memoryaccess #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_load(i_load), .i_store(i_store),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_rs2(i_rs2), .o_busy(o_busy),
    .o_done(o_done), .o_data_load(o_data_load), .o_misaligned(o_misaligned),
    .o_bus_err(o_bus_err), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr),
    .o_wdata(o_wdata), .o_sel(o_sel), .i_ack(i_ack), .i_rdata(i_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          dly;
    logic        bus;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works in byte counts and byte positions.
  function automatic int nbytes(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic vec_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic [31:0] rdata, input int dly);
    vec_t v;
    int n, off;
    longint val;
    n   = nbytes(f3);
    off = int'(addr % 4);
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.dly = dly;
    v.mis   = (ld || st) && ((addr % n) != 0);
    v.bus   = (ld || st) && !v.mis;
    v.we    = st;
    v.sel   = 4'(((1 << n) - 1) << off);
    v.waddr = addr - 32'(off);
    for (int i = 0; i < 4; i++) v.wdata[8*i +: 8] = rs2[8*(i % n) +: 8];
    val = longint'(rdata >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (!f3[2] && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
    v.data = (v.bus && !st) ? val[31:0] : 32'h0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    i_start = 1'b1; i_load = v.ld; i_store = v.st; i_funct3 = v.f3;
    i_addr = v.addr; i_rs2 = v.rs2; i_ack = 1'b0;
    @(negedge clk);
    i_start = 1'b0; i_load = 1'($urandom); i_store = 1'($urandom);
    i_funct3 = 3'($urandom); i_addr = $urandom; i_rs2 = $urandom;
    if (!v.bus) begin
      chk({tag, " nobus done"}, 32'(o_done), 32'd1);
      chk({tag, " nobus stb"}, 32'(o_stb), 32'd0);
      chk({tag, " nobus mis"}, 32'(o_misaligned), 32'(v.mis));
      chk({tag, " nobus err"}, 32'(o_bus_err), 32'd0);
      chk({tag, " nobus data"}, o_data_load, 32'd0);
      chk({tag, " nobus busy"}, 32'(o_busy), 32'd1);
    end else begin
      for (int c = 0; c <= v.dly; c++) begin
        chk({tag, " stb"}, 32'(o_stb), 32'd1);
        chk({tag, " we"}, 32'(o_we), 32'(v.we));
        chk({tag, " addr"}, o_addr, v.waddr);
        chk({tag, " sel"}, 32'(o_sel), 32'(v.sel));
        chk({tag, " wdata"}, o_wdata, v.wdata);
        chk({tag, " early done"}, 32'(o_done), 32'd0);
        chk({tag, " busy"}, 32'(o_busy), 32'd1);
        if (c == v.dly) begin i_ack = 1'b1; i_rdata = v.rdata; end
        else begin i_ack = 1'b0; i_rdata = $urandom; end
        @(negedge clk);
      end
      i_ack = 1'b0; i_rdata = $urandom;
      chk({tag, " done"}, 32'(o_done), 32'd1);
      chk({tag, " stb off"}, 32'(o_stb), 32'd0);
      chk({tag, " data"}, o_data_load, v.data);
      chk({tag, " mis"}, 32'(o_misaligned), 32'd0);
      chk({tag, " err"}, 32'(o_bus_err), 32'd0);
      chk({tag, " busy done"}, 32'(o_busy), 32'd1);
    end
    @(negedge clk);
    chk({tag, " post done"}, 32'(o_done), 32'd0);
    chk({tag, " post busy"}, 32'(o_busy), 32'd0);
    chk({tag, " hold data"}, o_data_load, v.data);
    chk({tag, " hold mis"}, 32'(o_misaligned), 32'(v.mis));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 32'(o_busy), 32'd0);
    chk({tag, " done"}, 32'(o_done), 32'd0);
    chk({tag, " data"}, o_data_load, 32'd0);
    chk({tag, " mis"}, 32'(o_misaligned), 32'd0);
    chk({tag, " err"}, 32'(o_bus_err), 32'd0);
    chk({tag, " stb"}, 32'(o_stb), 32'd0);
    chk({tag, " we"}, 32'(o_we), 32'd0);
    chk({tag, " addr"}, o_addr, 32'd0);
    chk({tag, " wdata"}, o_wdata, 32'd0);
    chk({tag, " sel"}, 32'(o_sel), 32'd0);
  endtask

  vec_t tbl[11];

  initial begin
    // ld st f3 addr rs2 rdata dly | bus we sel waddr wdata data mis
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 2,
                1'b1, 1'b0, 4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF_1234, 0,
                1'b1, 1'b0, 4'b1100, 32'h200, 32'h0, 32'h0000_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 3'b000, 32'h011, 32'h1234_56AB, 32'hDEAD_BEEF, 1,
                1'b1, 1'b1, 4'b0010, 32'h010, 32'hABAB_ABAB, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'b010, 32'h006, 32'h0, 32'h0, 0,
                1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 3'b001, 32'h005, 32'h0, 32'h0, 0,
                1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 32'h8001_7FFF, 3,
                1'b1, 1'b0, 4'b1100, 32'h000, 32'h0, 32'hFFFF_8001, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'b100, 32'h001, 32'h0, 32'h0000_9A00, 1,
                1'b1, 1'b0, 4'b0010, 32'h000, 32'h0, 32'h0000_009A, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 3'b010, 32'h008, 32'h0, 32'h0, 0,
                1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 3'b010, 32'h020, 32'hCAFE_F00D, 32'h1111_1111, 0,
                1'b1, 1'b1, 4'b1111, 32'h020, 32'hCAFE_F00D, 32'h0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3'b110, 32'h03C, 32'h0, 32'h8765_4321, 1,
                1'b1, 1'b0, 4'b1111, 32'h03C, 32'h0, 32'h8765_4321, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'b001, 32'h006, 32'h0000_A5C3, 32'h0, 2,
                1'b1, 1'b1, 4'b1100, 32'h004, 32'hA5C3_A5C3, 32'h0, 1'b0};

    rst = 1'b1; i_start = 1'b0; i_load = 1'b0; i_store = 1'b0; i_funct3 = 3'b0;
    i_addr = 32'h0; i_rs2 = 32'h0; i_ack = 1'b0; i_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      ld = 1'($urandom); st = 1'($urandom);
      if ($urandom_range(7) != 0 && !ld && !st) ld = 1'b1;
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(3) != 0) a = a & ~32'(nbytes(f3) - 1);
      run_vec(model(ld, st, f3, a, $urandom, $urandom, int'($urandom_range(TO - 1))),
              $sformatf("rnd%0d", i));
    end

    // Timeout: SW with no ack, then a spurious ack while idle.
    i_start = 1'b1; i_load = 1'b0; i_store = 1'b1; i_funct3 = 3'b010;
    i_addr = 32'h40; i_rs2 = 32'h5555_AAAA; i_ack = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < TO; c++) begin
      chk("to stb", 32'(o_stb), 32'd1);
      chk("to done early", 32'(o_done), 32'd0);
      @(negedge clk);
    end
    chk("to stb off", 32'(o_stb), 32'd0);
    chk("to done", 32'(o_done), 32'd1);
    chk("to err", 32'(o_bus_err), 32'd1);
    chk("to data", o_data_load, 32'd0);
    chk("to mis", 32'(o_misaligned), 32'd0);
    @(negedge clk);
    i_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("late ack stb", 32'(o_stb), 32'd0);
      chk("late ack done", 32'(o_done), 32'd0);
      chk("late ack busy", 32'(o_busy), 32'd0);
      chk("late ack err hold", 32'(o_bus_err), 32'd1);
    end
    i_ack = 1'b0;

    // Reset mid-transaction after a load leaves non-zero data behind.
    run_vec(tbl[9], "pre-rst");
    i_start = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h80;
    @(negedge clk);
    i_start = 1'b0;
    chk("rst pre stb", 32'(o_stb), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    i_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post rst done", 32'(o_done), 32'd0);
      chk("post rst stb", 32'(o_stb), 32'd0);
    end
    i_ack = 1'b0;

    // i_start while busy must not launch a second transaction.
    i_start = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h100;
    @(negedge clk);
    i_store = 1'b1; i_addr = 32'h200;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy start stb", 32'(o_stb), 32'd1);
    chk("busy start addr", o_addr, 32'h100);
    chk("busy start we", 32'(o_we), 32'd0);
    i_ack = 1'b1; i_rdata = 32'h1234_5678;
    @(negedge clk);
    i_ack = 1'b0;
    chk("busy start done", 32'(o_done), 32'd1);
    chk("busy start data", o_data_load, 32'h1234_5678);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no second stb", 32'(o_stb), 32'd0);
      chk("no second busy", 32'(o_busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
